// File: rtl/spm_product_collector.sv
`default_nettype none
// ============================================================================
// Module   : spm_product_collector
// Brief    : Collects the LSB-first serial product of the SPM core into a
//            2*WIDTH-bit parallel word and offers it with valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module spm_product_collector #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               p_serial,
  input  logic               ready,
  output logic [2*WIDTH-1:0] product,
  output logic               valid,
  output logic               busy
);

  localparam int c_pw = 2 * WIDTH;
  localparam int c_cw = $clog2(c_pw);
  localparam logic [c_cw-1:0] c_last = c_cw'(c_pw - 1);
  localparam logic [c_cw-1:0] c_one  = c_cw'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_cw-1:0] r_cnt;
  logic [c_cw-1:0] w_cnt_nxt;
  logic [c_pw-1:0] r_sr;
  logic [c_pw-1:0] w_sr_nxt;
  logic [c_pw-1:0] w_shifted;
  logic [c_pw-1:0] r_product;
  logic            r_valid;
  logic            r_busy;
  logic            w_load;

  // New bit enters at the top; after c_pw shifts bit k sits at position k.
  assign w_shifted = {p_serial, r_sr[c_pw-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_sr_nxt    = '0;
        end
      end
      S_SHIFT: begin
        if (start) begin
          // Restart: the bit presented alongside start is dropped.
          w_cnt_nxt = '0;
          w_sr_nxt  = '0;
        end else if (r_cnt == c_last) begin
          w_load      = 1'b1;
          w_state_nxt = S_DONE;
          w_cnt_nxt   = r_cnt + c_one;
          w_sr_nxt    = w_shifted;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
          w_sr_nxt  = w_shifted;
        end
      end
      S_DONE: begin
        if (ready) begin
          if (start) begin
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = '0;
            w_sr_nxt    = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_product <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sr    <= w_sr_nxt;
      if (w_load) begin
        r_product <= w_shifted;
      end
      // Flags are decoded from the next state so they line up with it.
      r_valid <= (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt == S_SHIFT);
    end
  end

  assign product = r_product;
  assign valid   = r_valid;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spm_product_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_spm_product_collector
// Brief    : Directed, table-driven bench for spm_product_collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spm_product_collector;

  localparam int WIDTH = 32;
  localparam int PW    = 2 * WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          p_serial;
  logic          ready;
  logic [PW-1:0] product;
  logic          valid;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  spm_product_collector #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .p_serial (p_serial),
    .ready    (ready),
    .product  (product),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] stream;
    logic [PW-1:0] expected;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, " busy after start"}, PW'(busy), PW'(1));
    chk({name, " valid after start"}, PW'(valid), PW'(0));
  endtask

  // Streams 64 bits LSB first; valid must appear exactly after the last bit.
  task automatic send_bits(input logic [PW-1:0] s, input logic [PW-1:0] exp, input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < PW; k++) begin
      p_serial = s[k];
      start    = 1'b0;
      tick();
      if (k < PW - 1 && (busy !== 1'b1 || valid !== 1'b0)) bad++;
    end
    chk({name, " early valid/busy drop"}, PW'(bad), PW'(0));
    chk({name, " valid"}, PW'(valid), PW'(1));
    chk({name, " busy"}, PW'(busy), PW'(0));
    chk({name, " product"}, product, exp);
  endtask

  initial begin
    // 3*5, (-1)*1, (-7)*3, 0x12345678*1, 0*0, and a pattern with both ends set
    vecs[0] = '{stream: 64'h0000_0000_0000_000F, expected: 64'h0000_0000_0000_000F};
    vecs[1] = '{stream: 64'hFFFF_FFFF_FFFF_FFFF, expected: 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{stream: 64'hFFFF_FFFF_FFFF_FFEB, expected: 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[3] = '{stream: 64'h0000_0000_1234_5678, expected: 64'h0000_0000_1234_5678};
    vecs[4] = '{stream: 64'h0000_0000_0000_0000, expected: 64'h0000_0000_0000_0000};
    vecs[5] = '{stream: 64'h8000_0000_0000_0001, expected: 64'h8000_0000_0000_0001};

    rst = 1'b1; start = 1'b0; p_serial = 1'b0; ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset product", product, '0);
    chk("reset valid", PW'(valid), PW'(0));
    chk("reset busy", PW'(busy), PW'(0));

    for (int i = 0; i < 6; i++) begin
      pulse_start($sformatf("vec%0d", i));
      send_bits(vecs[i].stream, vecs[i].expected, $sformatf("vec%0d", i));
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk($sformatf("vec%0d valid after handshake", i), PW'(valid), PW'(0));
      chk($sformatf("vec%0d busy after handshake", i), PW'(busy), PW'(0));
    end

    // Back-to-back: start together with ready in DONE
    pulse_start("b2b first");
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "b2b first");
    ready = 1'b1;
    start = 1'b1;
    tick();
    ready = 1'b0;
    start = 1'b0;
    chk("b2b valid drop", PW'(valid), PW'(0));
    chk("b2b busy restart", PW'(busy), PW'(1));
    send_bits(64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFEB, "b2b second");

    // Backpressure: DONE must ignore p_serial and start while ready is low
    for (int i = 0; i < 10; i++) begin
      p_serial = i[0];
      start    = i[0];
      tick();
      chk($sformatf("bp%0d product", i), product, 64'hFFFF_FFFF_FFFF_FFEB);
      chk($sformatf("bp%0d valid", i), PW'(valid), PW'(1));
      chk($sformatf("bp%0d busy", i), PW'(busy), PW'(0));
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("bp release valid", PW'(valid), PW'(0));
    chk("bp release busy", PW'(busy), PW'(0));
    tick();
    chk("idle valid", PW'(valid), PW'(0));
    chk("idle busy", PW'(busy), PW'(0));
    chk("idle product held", product, 64'hFFFF_FFFF_FFFF_FFEB);

    // Abort: 20 ones then restart
    pulse_start("abort first");
    for (int k = 0; k < 20; k++) begin
      p_serial = 1'b1;
      tick();
    end
    p_serial = 1'b1;
    pulse_start("abort restart");
    send_bits(64'h0000_0000_1234_5678, 64'h0000_0000_1234_5678, "abort");

    // Asynchronous reset while a product is pending in DONE
    #2 rst = 1'b1;
    #1;
    chk("async rst product", product, '0);
    chk("async rst valid", PW'(valid), PW'(0));
    chk("async rst busy", PW'(busy), PW'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst hold%0d product", i), product, '0);
      chk($sformatf("rst hold%0d valid/busy", i), PW'({valid, busy}), PW'(0));
    end
    rst = 1'b0;
    tick();

    // Reset after 40 bits of a collection
    pulse_start("midrst");
    for (int k = 0; k < 40; k++) begin
      p_serial = k[0];
      tick();
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst product", product, '0);
    chk("midrst valid/busy", PW'({valid, busy}), PW'(0));
    tick();
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 100; k++) begin
        p_serial = k[1];
        tick();
        if (valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      chk("midrst quiet 100 cycles", PW'(seen), PW'(0));
    end
    pulse_start("post rst");
    send_bits(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, "post rst");
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("post rst handshake", PW'(valid), PW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
